shift_unit_seq: RTL and testbench

//  Multicycle shifter for the MIPS datapath. Selects shift source and amount (ShifterMux), then

---
 rtl/shift_unit_seq_if.sv | 28 ++
 rtl/shift_unit_seq.sv | 125 ++++++++++++
 tb/tb_shift_unit_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_seq_if.sv
// Operand/handshake bundle for the multicycle shifter.
// The master drives the request and operands; the slave returns busy/done/result.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int IMM_W = 16
);
    logic             start;
    logic [1:0]       ShifterMux;
    logic [2:0]       op;
    logic [AMT_W-1:0] shamt;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [IMM_W-1:0] imediato;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, ShifterMux, op, shamt, A, B, imediato,
        input  busy, done, result
    );

    modport slave (
        input  start, ShifterMux, op, shamt, A, B, imediato,
        output busy, done, result
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multicycle shifter: captures a source/amount pair chosen by ShifterMux, then
// shifts the working register up to STEP bits per cycle until the amount is used up.
// busy/done are registered from the state, so they trail the state by one cycle:
// busy is high for exactly ceil(n/STEP) cycles and done pulses one cycle later.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int AMT_W   = 5,
    parameter int IMM_W   = 16,
    parameter int LUI_AMT = 16,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_unit_seq_if.slave  bus
);
    // A step larger than any representable amount behaves like "all remaining bits".
    localparam int unsigned AMT_MAX   = (1 << AMT_W) - 1;
    localparam int unsigned STEP_CLIP = (STEP > AMT_MAX) ? AMT_MAX : STEP;
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP_CLIP);

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic [AMT_W-1:0] remaining_reg;
    logic [2:0]       op_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] src_sel;
    logic [AMT_W-1:0] n_sel;
    logic [AMT_W-1:0] n_eff;
    logic             is_pass_in;
    logic             is_rot_in;
    logic [AMT_W-1:0] step_amt;
    logic [31:0]      step_w;
    logic [WIDTH-1:0] shifted;

    // Operand mux: source word and raw shift amount for each ShifterMux mode.
    always_comb begin
        src_sel = bus.A;
        n_sel   = bus.B[AMT_W-1:0];
        case (bus.ShifterMux)
            2'b00: begin src_sel = bus.A;              n_sel = bus.B[AMT_W-1:0]; end
            2'b01: begin src_sel = bus.B;              n_sel = bus.shamt;        end
            2'b10: begin src_sel = WIDTH'(bus.imediato); n_sel = AMT_W'(LUI_AMT); end
            default: begin src_sel = bus.B;            n_sel = bus.A[AMT_W-1:0]; end
        endcase
    end

    // Rotates only need the amount modulo WIDTH; linear shifts run the full count
    // so that oversized amounts naturally saturate to zero / sign fill.
    always_comb begin
        is_pass_in = (bus.op == 3'b000) || (bus.op[2:1] == 2'b11);
        is_rot_in  = (bus.op == OP_ROR) || (bus.op == OP_ROL);
        n_eff      = is_rot_in ? AMT_W'(32'(n_sel) % WIDTH) : n_sel;
    end

    assign step_amt = (remaining_reg < STEP_A) ? remaining_reg : STEP_A;
    assign step_w   = 32'(step_amt);

    // One iteration of the captured operation; step_amt is never 0 and, for
    // rotates, always below WIDTH while in SHIFT.
    always_comb begin
        shifted = result_reg;
        case (op_reg)
            OP_SLL:  shifted = result_reg << step_amt;
            OP_SRL:  shifted = result_reg >> step_amt;
            OP_SRA:  shifted = $signed(result_reg) >>> step_amt;
            OP_ROR:  shifted = (result_reg >> step_amt) | (result_reg << (32'(WIDTH) - step_w));
            OP_ROL:  shifted = (result_reg << step_amt) | (result_reg >> (32'(WIDTH) - step_w));
            default: shifted = result_reg;
        endcase
    end

    // Control FSM with registered busy/done and the working result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            remaining_reg <= '0;
            op_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            busy_reg <= (state_reg == SHIFT);
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    // The done cycle is still part of completion, so a request
                    // seen while done is high is dropped rather than queued.
                    if (bus.start && !done_reg) begin
                        result_reg    <= src_sel;
                        remaining_reg <= n_eff;
                        op_reg        <= bus.op;
                        state_reg     <= (is_pass_in || (n_eff == '0)) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    result_reg    <= shifted;
                    remaining_reg <= remaining_reg - step_amt;
                    if (remaining_reg == step_amt) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: one STEP=1 and one STEP=4 instance fed identical
// requests, checked against a plain-arithmetic reference of the shifter.
module tb_shift_unit_seq;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    shift_unit_seq_if #(.WIDTH(32), .AMT_W(5), .IMM_W(16)) bus1 ();
    shift_unit_seq_if #(.WIDTH(32), .AMT_W(5), .IMM_W(16)) bus4 ();

    assign bus4.start      = bus1.start;
    assign bus4.ShifterMux = bus1.ShifterMux;
    assign bus4.op         = bus1.op;
    assign bus4.shamt      = bus1.shamt;
    assign bus4.A          = bus1.A;
    assign bus4.B          = bus1.B;
    assign bus4.imediato   = bus1.imediato;

    shift_unit_seq #(.WIDTH(32), .AMT_W(5), .IMM_W(16), .LUI_AMT(16), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    shift_unit_seq #(.WIDTH(32), .AMT_W(5), .IMM_W(16), .LUI_AMT(16), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_src(logic [1:0] m, logic [31:0] a, logic [31:0] b, logic [15:0] imm);
        case (m)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return {16'h0000, imm};
            default: return b;
        endcase
    endfunction

    function automatic int ref_amt(logic [1:0] m, logic [4:0] sa, logic [31:0] a, logic [31:0] b);
        case (m)
            2'd0:    return int'(b % 32);
            2'd1:    return int'(sa);
            2'd2:    return 16;
            default: return int'(a % 32);
        endcase
    endfunction

    function automatic bit ref_pass(logic [2:0] o);
        return (o == 3'd0) || (o >= 3'd6);
    endfunction

    function automatic bit ref_rot(logic [2:0] o);
        return (o == 3'd4) || (o == 3'd5);
    endfunction

    function automatic logic [31:0] ref_result(logic [31:0] src, logic [2:0] o, int n);
        logic [63:0] dbl;
        int k;
        k = n % 32;
        dbl = {src, src};
        case (o)
            3'd1: return (n >= 32) ? 32'h0 : src << n;
            3'd2: return (n >= 32) ? 32'h0 : src >> n;
            3'd3: return (n >= 32) ? {32{src[31]}} : 32'($signed(src) >>> n);
            3'd4: begin dbl = dbl >> k; return dbl[31:0]; end
            3'd5: begin dbl = dbl << k; return dbl[63:32]; end
            default: return src;
        endcase
    endfunction

    // ---------------- driver / measurement (no checking here) ----------------
    task automatic run_op(input logic [1:0] m, input logic [2:0] o, input logic [4:0] sa,
                          input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                          input bit poke,
                          output int d1, output int d4, output int busy1, output int dcnt,
                          output logic [31:0] r1, output logic [31:0] r4);
        d1 = -1; d4 = -1; busy1 = 0; dcnt = 0; r1 = '0; r4 = '0;
        @(negedge clk);
        bus1.start = 1'b1; bus1.ShifterMux = m; bus1.op = o; bus1.shamt = sa;
        bus1.A = a; bus1.B = b; bus1.imediato = imm;
        @(posedge clk);
        #1;
        bus1.start      = 1'b0;
        bus1.ShifterMux = 2'($urandom_range(0, 3));
        bus1.op         = 3'($urandom_range(0, 7));
        bus1.shamt      = 5'($urandom_range(0, 31));
        bus1.A          = $urandom();
        bus1.B          = $urandom();
        bus1.imediato   = 16'($urandom());
        for (int k = 1; k <= 60 && (d1 < 0 || d4 < 0); k++) begin
            @(posedge clk);
            #1;
            bus1.start = (poke && k == 1);
            if (bus1.busy) busy1++;
            if (bus1.done) dcnt++;
            if (bus4.done) dcnt++;
            if (bus1.done && d1 < 0) begin d1 = k; r1 = bus1.result; end
            if (bus4.done && d4 < 0) begin d4 = k; r4 = bus4.result; end
        end
        bus1.start = 1'b0;
        @(posedge clk);
        #1;
        if (bus1.done) dcnt++;
        if (bus4.done) dcnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bus1.start = 1'b0; bus1.ShifterMux = 2'd0; bus1.op = 3'd0; bus1.shamt = '0;
        bus1.A = '0; bus1.B = '0; bus1.imediato = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b want 0", bus1.busy); end
        n_vec++; if (bus1.done !== 1'b0) begin n_bad++; $display("FAIL reset_done1: got %b want 0", bus1.done); end
        n_vec++; if (bus1.result !== 32'h0) begin n_bad++; $display("FAIL reset_result1: got %h want 0", bus1.result); end
        n_vec++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0 || bus4.result !== 32'h0) begin
            n_bad++; $display("FAIL reset_dut4: got busy=%b done=%b result=%h want 0/0/0", bus4.busy, bus4.done, bus4.result);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_sll_full;
        int d1, d4, b1, dc; logic [31:0] r1, r4;
        run_op(2'd0, 3'd1, 5'd0, 32'h1, 32'd31, 16'h0, 1'b1, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h80000000) begin n_bad++; $display("FAIL sll31_result: got %h want 80000000", r1); end
        n_vec++; if (d1 !== 32) begin n_bad++; $display("FAIL sll31_latency: got %0d want 32", d1); end
        n_vec++; if (b1 !== 31) begin n_bad++; $display("FAIL sll31_busy: got %0d want 31", b1); end
        n_vec++; if (r4 !== 32'h80000000 || d4 !== 9) begin n_bad++; $display("FAIL sll31_step4: got %h@%0d want 80000000@9", r4, d4); end
        n_vec++; if (dc !== 2) begin n_bad++; $display("FAIL sll31_done_pulses: got %0d want 2", dc); end
        $display("sll31: result=%h done@%0d busy=%0d step4=%h@%0d", r1, d1, b1, r4, d4);
    endtask

    task automatic test_lui;
        int d1, d4, b1, dc; logic [31:0] r1, r4;
        run_op(2'd2, 3'd1, 5'd3, 32'hFFFF, 32'h7, 16'h1234, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h12340000 || d1 !== 17) begin n_bad++; $display("FAIL lui: got %h@%0d want 12340000@17", r1, d1); end
        n_vec++; if (r4 !== 32'h12340000 || d4 !== 5) begin n_bad++; $display("FAIL lui_step4: got %h@%0d want 12340000@5", r4, d4); end
        $display("lui: result=%h done@%0d", r1, d1);
    endtask

    task automatic test_right_shifts;
        int d1, d4, b1, dc; logic [31:0] r1, r4;
        run_op(2'd1, 3'd3, 5'd4, 32'h0, 32'h800000F0, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'hF800000F || r4 !== 32'hF800000F) begin n_bad++; $display("FAIL sra4: got %h/%h want F800000F", r1, r4); end
        n_vec++; if (d1 !== 5 || b1 !== 4 || d4 !== 2) begin n_bad++; $display("FAIL sra4_timing: got %0d/%0d/%0d want 5/4/2", d1, b1, d4); end
        $display("sra4: result=%h done@%0d", r1, d1);
        run_op(2'd1, 3'd2, 5'd4, 32'h0, 32'h800000F0, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h0800000F || r4 !== 32'h0800000F) begin n_bad++; $display("FAIL srl4: got %h/%h want 0800000F", r1, r4); end
        $display("srl4: result=%h done@%0d", r1, d1);
    endtask

    task automatic test_rotate;
        int d1, d4, b1, dc; logic [31:0] r1, r4;
        run_op(2'd3, 3'd4, 5'd0, 32'd8, 32'h12345678, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h78123456 || d1 !== 9) begin n_bad++; $display("FAIL ror8: got %h@%0d want 78123456@9", r1, d1); end
        n_vec++; if (r4 !== 32'h78123456 || d4 !== 3) begin n_bad++; $display("FAIL ror8_step4: got %h@%0d want 78123456@3", r4, d4); end
        $display("ror8: result=%h done@%0d step4@%0d", r1, d1, d4);
        run_op(2'd3, 3'd5, 5'd0, 32'd8, 32'h12345678, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h34567812 || r4 !== 32'h34567812) begin n_bad++; $display("FAIL rol8: got %h/%h want 34567812", r1, r4); end
        $display("rol8: result=%h done@%0d", r1, d1);
    endtask

    task automatic test_zero_and_pass;
        int d1, d4, b1, dc; logic [31:0] r1, r4;
        run_op(2'd1, 3'd1, 5'd0, 32'h0, 32'hDEADBEEF, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'hDEADBEEF || d1 !== 1 || b1 !== 0) begin n_bad++; $display("FAIL zero_amt: got %h@%0d busy=%0d want DEADBEEF@1 busy=0", r1, d1, b1); end
        $display("zero_amt: result=%h done@%0d", r1, d1);
        run_op(2'd0, 3'd0, 5'd9, 32'hCAFEF00D, 32'd7, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'hCAFEF00D || d1 !== 1 || d4 !== 1) begin n_bad++; $display("FAIL pass000: got %h@%0d/%0d want CAFEF00D@1/1", r1, d1, d4); end
        $display("pass000: result=%h done@%0d", r1, d1);
        run_op(2'd1, 3'd7, 5'd12, 32'h0, 32'h0BADF00D, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== 32'h0BADF00D || d1 !== 1) begin n_bad++; $display("FAIL pass111: got %h@%0d want 0BADF00D@1", r1, d1); end
        $display("pass111: result=%h done@%0d", r1, d1);
    endtask

    task automatic test_random;
        int d1, d4, b1, dc, n, neff, lat1, lat4, bexp;
        logic [31:0] r1, r4, a, b, src, exp;
        logic [15:0] imm; logic [1:0] m; logic [2:0] o; logic [4:0] sa; bit act;
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3)); o = 3'($urandom_range(0, 7)); sa = 5'($urandom_range(0, 31));
            a = $urandom(); b = $urandom(); imm = 16'($urandom());
            src  = ref_src(m, a, b, imm);
            n    = ref_amt(m, sa, a, b);
            neff = ref_rot(o) ? n % 32 : n;
            act  = !ref_pass(o) && neff != 0;
            exp  = ref_pass(o) ? src : ref_result(src, o, n);
            lat1 = act ? 1 + neff : 1;
            lat4 = act ? 1 + (neff + 3) / 4 : 1;
            bexp = act ? neff : 0;
            run_op(m, o, sa, a, b, imm, 1'b0, d1, d4, b1, dc, r1, r4);
            n_vec++;
            if (r1 !== exp || r4 !== exp || d1 !== lat1 || d4 !== lat4 || b1 !== bexp || dc !== 2) begin
                n_bad++;
                $display("FAIL rand%0d: got %h/%h @%0d/%0d busy=%0d pulses=%0d want %h @%0d/%0d busy=%0d pulses=2",
                         i, r1, r4, d1, d4, b1, dc, exp, lat1, lat4, bexp);
            end
            $display("rand%0d: mode=%0d op=%0d n=%0d src=%h result=%h done@%0d", i, m, o, n, src, r1, d1);
        end
    endtask

    task automatic test_reset_abort;
        int d1, d4, b1, dc, seen; logic [31:0] r1, r4, bval;
        bval = $urandom() | 32'h1;
        @(negedge clk);
        bus1.start = 1'b1; bus1.ShifterMux = 2'd1; bus1.op = 3'd1; bus1.shamt = 5'd20; bus1.B = bval;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (bus1.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", bus1.busy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.result !== 32'h0) begin
            n_bad++; $display("FAIL abort_state1: got busy=%b done=%b result=%h want 0/0/0", bus1.busy, bus1.done, bus1.result);
        end
        n_vec++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.result !== 32'h0) begin
            n_bad++; $display("FAIL abort_state4: got busy=%b done=%b result=%h want 0/0/0", bus4.busy, bus4.done, bus4.result);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus1.done || bus4.done || bus1.busy || bus4.busy) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        run_op(2'd1, 3'd1, 5'd20, 32'h0, bval, 16'h0, 1'b0, d1, d4, b1, dc, r1, r4);
        n_vec++; if (r1 !== (bval << 20) || d1 !== 21 || r4 !== (bval << 20) || d4 !== 6) begin
            n_bad++; $display("FAIL abort_next_op: got %h@%0d/%h@%0d want %h@21/6", r1, d1, r4, d4, bval << 20);
        end
        $display("abort: next op result=%h done@%0d", r1, d1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_sll_full();
        test_lui();
        test_right_shifts();
        test_rotate();
        test_zero_and_pass();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
